// File: rtl/pss_sync_pkg.sv
// pss_sync_pkg
//   Shared definitions for the PSS synchronisation controller and the
//   PSS_detector it sequences: detector mode encodings, controller state
//   enum and the default SSB timing parameters.
package pss_sync_pkg;

  typedef logic [1:0] mode_t;

  // Detector mode_i encodings, shared with PSS_detector.
  localparam mode_t MODE_SEARCH = 2'd0;
  localparam mode_t MODE_FIND   = 2'd1;
  localparam mode_t MODE_PAUSE  = 2'd2;

  // 20 ms SSB period at 1.92 MSPS.
  localparam int unsigned SSB_PERIOD_DEFAULT  = 38400;
  localparam int unsigned WINDOW_HALF_DEFAULT = 100;
  localparam int unsigned MAX_MISSES_DEFAULT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_PAUSE,
    ST_FIND
  } state_e;

  // Detector mode requested while the controller sits in a given state.
  function automatic mode_t state_to_mode(input state_e st);
    case (st)
      ST_SEARCH: return MODE_SEARCH;
      ST_FIND:   return MODE_FIND;
      default:   return MODE_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/pss_sync_controller_if.sv
// pss_sync_controller_if
//   Link between the sync controller and PSS_detector.
//   s_axis_in_tvalid  : sample strobe seen by both blocks
//   N_id_2            : detected N_id_2 from the detector
//   N_id_2_valid      : one-cycle detection pulse from the detector
//   mode              : detector mode_i (SEARCH/FIND/PAUSE)
//   requested_N_id_2  : detector requested_N_id_2_i
//   master = controller side, slave = detector/source side.
interface pss_sync_controller_if;
  import pss_sync_pkg::*;

  logic        s_axis_in_tvalid;
  logic [1:0]  N_id_2;
  logic        N_id_2_valid;
  mode_t       mode;
  logic [1:0]  requested_N_id_2;

  modport master (
    input  s_axis_in_tvalid, N_id_2, N_id_2_valid,
    output mode, requested_N_id_2
  );

  modport slave (
    output s_axis_in_tvalid, N_id_2, N_id_2_valid,
    input  mode, requested_N_id_2
  );

endinterface

// File: rtl/pss_sync_controller.sv
// pss_sync_controller
//   Sequences PSS_detector through SEARCH, PAUSE and FIND. After the first
//   detection it locks onto one N_id_2, counts samples to predict the next
//   SSB, opens a +/-WINDOW_HALF FIND window around it and falls back to
//   SEARCH after MAX_MISSES consecutive empty windows.
// Ports:
//   clk_i, reset_ni   : clock, asynchronous active-low reset
//   enable_i          : level enable, 0 forces IDLE
//   det               : detector link (tvalid, detections in; mode, request out)
//   locked_o          : tracking (PAUSE or FIND)
//   N_id_2_o          : locked N_id_2
//   ssb_strobe_o      : pulse per accepted detection
//   timing_error_o    : signed detection position minus SSB_PERIOD
//   miss_cnt_o        : consecutive missed windows
module pss_sync_controller
  import pss_sync_pkg::*;
#(
  parameter int unsigned SSB_PERIOD  = SSB_PERIOD_DEFAULT,
  parameter int unsigned WINDOW_HALF = WINDOW_HALF_DEFAULT,
  parameter int unsigned MAX_MISSES  = MAX_MISSES_DEFAULT,
  parameter int unsigned CNT_W       = $clog2(SSB_PERIOD + WINDOW_HALF + 1),
  parameter int unsigned ERR_W       = $clog2(WINDOW_HALF + 1) + 1,
  localparam int unsigned MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    enable_i,
  pss_sync_controller_if.master   det,
  output logic                    locked_o,
  output logic [1:0]              N_id_2_o,
  output logic                    ssb_strobe_o,
  output logic signed [ERR_W-1:0] timing_error_o,
  output logic [MISS_W-1:0]       miss_cnt_o
);

  // Last PAUSE sample before the window; window close sample; count that
  // keeps the next window on the nominal grid after a miss.
  localparam logic [CNT_W-1:0]  OPEN_CNT   = CNT_W'(SSB_PERIOD - WINDOW_HALF - 1);
  localparam logic [CNT_W-1:0]  CLOSE_CNT  = CNT_W'(SSB_PERIOD + WINDOW_HALF);
  localparam logic [CNT_W-1:0]  REGRID_CNT = CNT_W'(WINDOW_HALF + 1);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic [1:0]          nid_q, nid_d;
  logic                accept, window_close;
  logic signed [CNT_W:0] err_full;

  mode_t               mode_d;
  logic                locked_d, strobe_d;
  logic signed [ERR_W-1:0] err_d;

  // Disable dominates: a detection coinciding with enable_i=0 is dropped.
  assign accept = enable_i && det.N_id_2_valid &&
                  (state_q == ST_SEARCH ||
                   (state_q == ST_FIND && det.N_id_2 == nid_q));

  // Acceptance wins over a simultaneous window close.
  assign window_close = (state_q == ST_FIND) && det.s_axis_in_tvalid &&
                        (cnt_q == CLOSE_CNT) && !accept;

  assign miss_inc = miss_q + MISS_W'(1);
  assign err_full = $signed({1'b0, cnt_q}) - $signed({1'b0, CNT_W'(SSB_PERIOD)});

  // Next-state, counter and miss bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = det.s_axis_in_tvalid ? cnt_q + CNT_W'(1) : cnt_q;
    miss_d  = miss_q;
    nid_d   = nid_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_SEARCH;
        ST_SEARCH: if (accept) state_d = ST_PAUSE;
        ST_PAUSE:  if (det.s_axis_in_tvalid && cnt_q == OPEN_CNT) state_d = ST_FIND;
        ST_FIND: begin
          if (accept) begin
            state_d = ST_PAUSE;
          end else if (window_close) begin
            cnt_d = REGRID_CNT;
            if (miss_inc == MISS_LIMIT) begin
              state_d = ST_SEARCH;
              miss_d  = '0;
            end else begin
              state_d = ST_PAUSE;
              miss_d  = miss_inc;
            end
          end
        end
      endcase
      if (accept) begin
        cnt_d  = '0;
        miss_d = '0;
        nid_d  = det.N_id_2;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    mode_d   = state_to_mode(state_d);
    locked_d = (state_d == ST_PAUSE) || (state_d == ST_FIND);
    strobe_d = accept;
    err_d    = timing_error_o;
    if (accept) begin
      err_d = (state_q == ST_SEARCH) ? '0 : err_full[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      miss_q         <= '0;
      nid_q          <= '0;
      det.mode       <= MODE_PAUSE;
      locked_o       <= 1'b0;
      ssb_strobe_o   <= 1'b0;
      timing_error_o <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      miss_q         <= miss_d;
      nid_q          <= nid_d;
      det.mode       <= mode_d;
      locked_o       <= locked_d;
      ssb_strobe_o   <= strobe_d;
      timing_error_o <= err_d;
    end
  end

  assign N_id_2_o             = nid_q;
  assign det.requested_N_id_2 = nid_q;
  assign miss_cnt_o           = miss_q;

endmodule

// File: tb/tb_pss_sync_controller.sv
// tb_pss_sync_controller
//   Randomised bench with a sample-position reference model. Uses a short
//   SSB period so several windows fit in a short run.
module tb_pss_sync_controller;
  import pss_sync_pkg::*;

  localparam int P      = 400;
  localparam int W      = 20;
  localparam int M      = 3;
  localparam int ERR_W  = $clog2(W + 1) + 1;
  localparam int MISS_W = $clog2(M + 1);

  logic clk, reset_ni, enable;
  logic locked_o, ssb_strobe_o;
  logic [1:0] N_id_2_o;
  logic signed [ERR_W-1:0] timing_error_o;
  logic [MISS_W-1:0] miss_cnt_o;

  pss_sync_controller_if det_if ();

  pss_sync_controller #(.SSB_PERIOD(P), .WINDOW_HALF(W), .MAX_MISSES(M)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable), .det(det_if),
    .locked_o(locked_o), .N_id_2_o(N_id_2_o), .ssb_strobe_o(ssb_strobe_o),
    .timing_error_o(timing_error_o), .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: position in samples relative to the last SSB.
  int   m_pos, m_miss;
  bit   m_idle, m_locked, m_strobe;
  logic [1:0] m_nid;
  mode_t m_mode;
  logic signed [ERR_W-1:0] m_err;

  task automatic model_reset();
    m_idle = 1; m_locked = 0; m_miss = 0; m_pos = 0;
    m_nid = 0; m_mode = MODE_PAUSE; m_strobe = 0; m_err = '0;
  endtask

  task automatic model_update(input bit tv, input bit nv, input logic [1:0] nid, input bit en);
    bit in_win;
    m_strobe = 0;
    if (!en) begin
      m_idle = 1; m_locked = 0; m_miss = 0; m_pos = 0;
    end else if (m_idle) begin
      m_idle = 0; m_pos += int'(tv);
    end else if (!m_locked) begin
      if (nv) begin
        m_locked = 1; m_nid = nid; m_pos = 0; m_miss = 0; m_strobe = 1; m_err = '0;
      end else m_pos += int'(tv);
    end else begin
      in_win = (m_pos >= P - W);
      if (nv && in_win && nid == m_nid) begin
        m_err = ERR_W'(m_pos - P); m_pos = 0; m_miss = 0; m_strobe = 1;
      end else if (in_win && tv && m_pos == P + W) begin
        m_miss++; m_pos = W + 1;
        if (m_miss == M) begin m_locked = 0; m_miss = 0; end
      end else m_pos += int'(tv);
    end
    m_mode = m_idle ? MODE_PAUSE : (!m_locked ? MODE_SEARCH :
             ((m_pos >= P - W) ? MODE_FIND : MODE_PAUSE));
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit tv, input bit nv, input logic [1:0] nid, input bit en);
    det_if.s_axis_in_tvalid = tv;
    det_if.N_id_2_valid     = nv;
    det_if.N_id_2           = nid;
    enable                  = en;
    @(posedge clk);
    if (reset_ni) model_update(tv, nv, nid, en);
    #1;
  endtask

  // Random stimulus until mode_o equals target; reports samples consumed and
  // cycles on which the DUT disagreed with the model.
  task automatic run_until(input mode_t target, input int tv_pct, input int noise_pct,
                           output int samples, output bit reached, output int diverge);
    bit tv, nv;
    samples = 0; reached = 0; diverge = 0;
    for (int i = 0; i < 4000; i++) begin
      tv = ($urandom_range(99) < tv_pct);
      nv = ($urandom_range(99) < noise_pct);
      step(tv, nv, 2'($urandom_range(2)), 1'b1);
      samples += int'(tv);
      if (det_if.mode !== m_mode || ssb_strobe_o !== m_strobe ||
          locked_o !== m_locked || miss_cnt_o !== MISS_W'(m_miss)) diverge++;
      if (det_if.mode === target) begin reached = 1; break; end
    end
  endtask

  // Random tvalid without detections until the model sits at position pos.
  task automatic run_to_pos(input int pos);
    for (int i = 0; i < 4000 && m_pos < pos; i++) step(1'($urandom_range(1)), 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(2)), 1'b1);
      checks++; if (det_if.mode !== MODE_PAUSE) begin failures++; $display("FAIL reset_mode: got %0d want 2", det_if.mode); end
      checks++; if ({locked_o, ssb_strobe_o, miss_cnt_o} !== '0) begin failures++; $display("FAIL reset_flags: got lock=%b strobe=%b miss=%0d want 0", locked_o, ssb_strobe_o, miss_cnt_o); end
      checks++; if ({N_id_2_o, det_if.requested_N_id_2, timing_error_o} !== '0) begin failures++; $display("FAIL reset_values: got nid=%0d req=%0d err=%0d want 0", N_id_2_o, det_if.requested_N_id_2, timing_error_o); end
    end
    reset_ni = 1'b1;
    step(1'b1, 1'b0, 2'd0, 1'b1);
    checks++; if (det_if.mode !== MODE_SEARCH) begin failures++; $display("FAIL enable_search: got %0d want 0", det_if.mode); end
  endtask

  task automatic test_acquire();
    int s, d; bit r;
    for (int i = 0; i < 20; i++) step(1'($urandom_range(1)), 1'b0, 2'd0, 1'b1);
    checks++; if (det_if.mode !== MODE_SEARCH || locked_o !== 1'b0) begin failures++; $display("FAIL search_hold: got mode=%0d lock=%b want 0/0", det_if.mode, locked_o); end
    step(1'b1, 1'b1, 2'd1, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b1) begin failures++; $display("FAIL acq_strobe: got %b want 1", ssb_strobe_o); end
    checks++; if (N_id_2_o !== 2'd1 || det_if.requested_N_id_2 !== 2'd1) begin failures++; $display("FAIL acq_nid: got %0d/%0d want 1/1", N_id_2_o, det_if.requested_N_id_2); end
    checks++; if (locked_o !== 1'b1 || det_if.mode !== MODE_PAUSE) begin failures++; $display("FAIL acq_state: got lock=%b mode=%0d want 1/2", locked_o, det_if.mode); end
    checks++; if (timing_error_o !== '0) begin failures++; $display("FAIL acq_err: got %0d want 0", timing_error_o); end
    run_until(MODE_FIND, 70, 5, s, r, d);
    checks++; if (!r || s !== P - W) begin failures++; $display("FAIL acq_window_open: got reached=%b samples=%0d want 1/%0d", r, s, P - W); end
    checks++; if (d !== 0) begin failures++; $display("FAIL acq_model: got %0d divergent cycles want 0", d); end
  endtask

  task automatic test_track();
    step(1'b1, 1'b1, 2'd2, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b0 || det_if.mode !== MODE_FIND) begin failures++; $display("FAIL wrong_nid: got strobe=%b mode=%0d want 0/1", ssb_strobe_o, det_if.mode); end
    run_to_pos(P + 5);
    checks++; if (det_if.mode !== MODE_FIND) begin failures++; $display("FAIL track_in_window: got %0d want 1", det_if.mode); end
    step(1'($urandom_range(1)), 1'b1, 2'd1, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b1 || timing_error_o !== ERR_W'(5)) begin failures++; $display("FAIL track_err: got strobe=%b err=%0d want 1/5", ssb_strobe_o, timing_error_o); end
    checks++; if (miss_cnt_o !== '0 || det_if.mode !== MODE_PAUSE) begin failures++; $display("FAIL track_state: got miss=%0d mode=%0d want 0/2", miss_cnt_o, det_if.mode); end
  endtask

  task automatic test_misses();
    int s, d; bit r;
    run_until(MODE_FIND, 60, 5, s, r, d);
    checks++; if (!r || s !== P - W || d !== 0) begin failures++; $display("FAIL miss_open1: got r=%b samples=%0d div=%0d want 1/%0d/0", r, s, d, P - W); end
    for (int k = 1; k <= M; k++) begin
      run_until(k == M ? MODE_SEARCH : MODE_PAUSE, 60, 0, s, r, d);
      checks++; if (!r || s !== 2 * W + 1 || d !== 0) begin failures++; $display("FAIL miss_close%0d: got r=%b samples=%0d div=%0d want 1/%0d/0", k, r, s, d, 2 * W + 1); end
      if (k < M) begin
        checks++; if (miss_cnt_o !== MISS_W'(k) || locked_o !== 1'b1) begin failures++; $display("FAIL miss_cnt%0d: got %0d lock=%b want %0d/1", k, miss_cnt_o, locked_o, k); end
        run_until(MODE_FIND, 60, 5, s, r, d);
        checks++; if (!r || s !== P - 2 * W - 1 || d !== 0) begin failures++; $display("FAIL miss_reopen%0d: got r=%b samples=%0d div=%0d want 1/%0d/0", k, r, s, d, P - 2 * W - 1); end
      end
    end
    checks++; if (locked_o !== 1'b0 || miss_cnt_o !== '0 || det_if.mode !== MODE_SEARCH) begin failures++; $display("FAIL lock_lost: got lock=%b miss=%0d mode=%0d want 0/0/0", locked_o, miss_cnt_o, det_if.mode); end
  endtask

  task automatic test_boundary();
    int s, d; bit r;
    step(1'b0, 1'b1, 2'd2, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b1 || N_id_2_o !== 2'd2) begin failures++; $display("FAIL reacq: got strobe=%b nid=%0d want 1/2", ssb_strobe_o, N_id_2_o); end
    step(1'b1, 1'b1, 2'd2, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b0 || det_if.mode !== MODE_PAUSE) begin failures++; $display("FAIL pause_ignore: got strobe=%b mode=%0d want 0/2", ssb_strobe_o, det_if.mode); end
    run_until(MODE_FIND, 80, 0, s, r, d);
    checks++; if (!r || s !== P - W - 1 || d !== 0) begin failures++; $display("FAIL bnd_open: got r=%b samples=%0d div=%0d want 1/%0d/0", r, s, d, P - W - 1); end
    step(1'b0, 1'b1, 2'd2, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b1 || timing_error_o !== ERR_W'(-W)) begin failures++; $display("FAIL early_edge: got strobe=%b err=%0d want 1/%0d", ssb_strobe_o, timing_error_o, -W); end
    run_until(MODE_FIND, 80, 3, s, r, d);
    run_to_pos(P + W);
    checks++; if (det_if.mode !== MODE_FIND || m_pos !== P + W) begin failures++; $display("FAIL late_pre: got mode=%0d pos=%0d want 1/%0d", det_if.mode, m_pos, P + W); end
    step(1'b1, 1'b1, 2'd2, 1'b1);
    checks++; if (ssb_strobe_o !== 1'b1 || timing_error_o !== ERR_W'(W)) begin failures++; $display("FAIL late_edge: got strobe=%b err=%0d want 1/%0d", ssb_strobe_o, timing_error_o, W); end
    checks++; if (miss_cnt_o !== '0 || det_if.mode !== MODE_PAUSE) begin failures++; $display("FAIL late_no_miss: got miss=%0d mode=%0d want 0/2", miss_cnt_o, det_if.mode); end
  endtask

  task automatic test_abort();
    int s, d; bit r;
    run_until(MODE_FIND, 70, 5, s, r, d);
    step(1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    checks++; if (det_if.mode !== MODE_PAUSE || locked_o !== 1'b0 || miss_cnt_o !== '0) begin failures++; $display("FAIL disable: got mode=%0d lock=%b miss=%0d want 2/0/0", det_if.mode, locked_o, miss_cnt_o); end
    checks++; if (N_id_2_o !== m_nid) begin failures++; $display("FAIL disable_hold: got %0d want %0d", N_id_2_o, m_nid); end
    step(1'b1, 1'b0, 2'd0, 1'b1);
    checks++; if (det_if.mode !== MODE_SEARCH) begin failures++; $display("FAIL reenable: got %0d want 0", det_if.mode); end
    step(1'b1, 1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), 1'b0, 2'd0, 1'b1);
    checks++; if (det_if.mode !== MODE_PAUSE || locked_o !== 1'b1 || N_id_2_o !== 2'd1) begin failures++; $display("FAIL pre_reset: got mode=%0d lock=%b nid=%0d want 2/1/1", det_if.mode, locked_o, N_id_2_o); end
    #2 reset_ni = 1'b0;
    #1;
    checks++; if (det_if.mode !== MODE_PAUSE || {locked_o, ssb_strobe_o, miss_cnt_o} !== '0) begin failures++; $display("FAIL async_reset_ctl: got mode=%0d lock=%b strobe=%b miss=%0d", det_if.mode, locked_o, ssb_strobe_o, miss_cnt_o); end
    checks++; if ({N_id_2_o, det_if.requested_N_id_2, timing_error_o} !== '0) begin failures++; $display("FAIL async_reset_data: got nid=%0d req=%0d err=%0d want 0", N_id_2_o, det_if.requested_N_id_2, timing_error_o); end
    model_reset();
    step(1'b1, 1'b0, 2'd0, 1'b1);
    reset_ni = 1'b1;
  endtask

  initial begin
    reset_ni = 1'b0;
    enable = 1'b0;
    det_if.s_axis_in_tvalid = 1'b0;
    det_if.N_id_2_valid = 1'b0;
    det_if.N_id_2 = 2'd0;
    model_reset();
    test_reset();
    test_acquire();
    test_track();
    test_misses();
    test_boundary();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
